lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_if.sv | 40 ++++
 rtl/lsu_align.sv | 33 +++
 rtl/lsu.sv | 129 ++++++++++++
 tb/tb_lsu.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared LSU types, load-type codes and lane constants
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_t;

  localparam logic [2:0] LD_LW  = 3'd1;
  localparam logic [2:0] LD_LD  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd4;

  localparam int LANE_SHIFT_W = 3;

  function automatic logic is_load(input logic [2:0] ld_type);
    return (ld_type == LD_LW) || (ld_type == LD_LD) || (ld_type == LD_LBU);
  endfunction

  // Only ld/sd, lw and sh have alignment rules; other accesses are never flagged.
  function automatic logic misaligned(input logic [LANE_SHIFT_W-1:0] off, input logic store,
                                      input logic [7:0] wmask, input logic [2:0] ld_type);
    logic dword;
    logic word;
    logic half;
    dword = store ? (wmask == 8'hFF) : (ld_type == LD_LD);
    word  = !store && (ld_type == LD_LW);
    half  = store && (wmask == 8'h03);
    return (dword && (off != 3'd0)) || (word && (off[1:0] != 2'd0)) || (half && off[0]);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - execute-stage request/response and memory port bundle for the LSU
interface lsu_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [7:0]        req_wmask;
  logic              req_store;
  logic [2:0]        req_ld_type;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wen;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wmask;
  logic              mem_rsp_valid;
  logic [63:0]       mem_rdata;

  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic              busy;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wmask, req_store, req_ld_type,
    input  mem_req_ready, mem_rsp_valid, mem_rdata,
    output req_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    output resp_valid, resp_rdata, resp_err, busy
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_wmask, req_store, req_ld_type,
    output mem_req_ready, mem_rsp_valid, mem_rdata,
    input  req_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask,
    input  resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store lane shift and load extract/extend for one 64-bit beat
module lsu_align
  import lsu_pkg::*;
(
  input  logic [LANE_SHIFT_W-1:0] i_off,
  input  logic                    i_store,
  input  logic [63:0]             i_wdata,
  input  logic [7:0]              i_wmask,
  input  logic [63:0]             i_rdata,
  input  logic [2:0]              i_ld_type,
  output logic [63:0]             o_wdata,
  output logic [7:0]              o_wmask,
  output logic [63:0]             o_ldata
);
  logic [5:0]  w_bit_off;
  logic [63:0] w_shifted;

  assign w_bit_off = {i_off, 3'b000};
  assign o_wdata   = i_wdata << w_bit_off;
  // Mask bits pushed past byte 7 fall off the beat.
  assign o_wmask   = i_store ? (i_wmask << i_off) : 8'h00;
  assign w_shifted = i_rdata >> w_bit_off;

  always_comb begin
    o_ldata = 64'd0;
    case (i_ld_type)
      LD_LW:   o_ldata = {{32{w_shifted[31]}}, w_shifted[31:0]};
      LD_LD:   o_ldata = w_shifted;
      LD_LBU:  o_ldata = {56'd0, w_shifted[7:0]};
      default: o_ldata = 64'd0;
    endcase
  end
endmodule

// File: rtl/lsu.sv
// rtl/lsu.sv - single-outstanding load/store unit with memory timeout
// Optional misaligned-access trap: define LSU_MISALIGN_CHECK_EN.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int TIMEOUT_CYC = 255
) (
  input logic  clk,
  input logic  rst,
  lsu_if.slave bus
);
  localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [63:0]       r_wdata;
  logic [7:0]        r_wmask;
  logic              r_store;
  logic [2:0]        r_ld_type;
  logic [TMO_W-1:0]  r_tmo;
  logic [63:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_misalign;
  logic              w_capture;
  logic              w_timeout;
  logic [63:0]       w_lane_wdata;
  logic [7:0]        w_lane_wmask;
  logic [63:0]       w_load_data;

  lsu_align u_align (
    .i_off     (r_addr[LANE_SHIFT_W-1:0]),
    .i_store   (r_store),
    .i_wdata   (r_wdata),
    .i_wmask   (r_wmask),
    .i_rdata   (bus.mem_rdata),
    .i_ld_type (r_ld_type),
    .o_wdata   (w_lane_wdata),
    .o_wmask   (w_lane_wmask),
    .o_ldata   (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_misalign = 1'b0;
    w_capture  = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid && (bus.req_store || is_load(bus.req_ld_type))) begin
          w_accept = 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
          w_misalign = misaligned(bus.req_addr[LANE_SHIFT_W-1:0], bus.req_store,
                                  bus.req_wmask, bus.req_ld_type);
`endif
          w_next = w_misalign ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_req_ready) begin
          w_capture = bus.mem_rsp_valid;
          w_next    = bus.mem_rsp_valid ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_rsp_valid) begin
          w_capture = 1'b1;
          w_next    = ST_DONE;
        end else if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
          w_timeout = 1'b1;
          w_next    = ST_DONE;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_wdata   <= 64'd0;
      r_wmask   <= 8'd0;
      r_store   <= 1'b0;
      r_ld_type <= 3'd0;
      r_tmo     <= '0;
      r_rdata   <= 64'd0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr    <= bus.req_addr;
        r_wdata   <= bus.req_wdata;
        r_wmask   <= bus.req_wmask;
        r_store   <= bus.req_store;
        r_ld_type <= bus.req_ld_type;
      end
      if (w_misalign || w_timeout) begin
        r_rdata <= 64'd0;
        r_err   <= 1'b1;
      end else if (w_capture) begin
        r_rdata <= r_store ? 64'd0 : w_load_data;
        r_err   <= 1'b0;
      end
      // Counter only runs while we stay in WAIT, so any exit leaves it cleared.
      if ((r_state == ST_WAIT) && (w_next == ST_WAIT)) r_tmo <= r_tmo + TMO_W'(1);
      else                                             r_tmo <= '0;
    end
  end

  assign bus.req_ready     = (r_state == ST_IDLE);
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.mem_req_valid = (r_state == ST_REQ);
  assign bus.mem_addr      = {r_addr[ADDR_W-1:LANE_SHIFT_W], {LANE_SHIFT_W{1'b0}}};
  assign bus.mem_wen       = r_store;
  assign bus.mem_wdata     = w_lane_wdata;
  assign bus.mem_wmask     = w_lane_wmask;
  assign bus.resp_valid    = (r_state == ST_DONE);
  assign bus.resp_rdata    = r_rdata;
  assign bus.resp_err      = r_err;
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - directed and randomized checks of lsu against a byte-level model
module tb_lsu;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  lsu_if #(.ADDR_W(64)) bus ();

  lsu #(.ADDR_W(64), .TIMEOUT_CYC(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off, input logic [2:0] ldt);
    logic [63:0] v;
    int n;
    v = 64'd0;
    n = (ldt == 3'd1) ? 4 : (ldt == 3'd2) ? 8 : 1;
    for (int i = 0; i < n; i++)
      if (off + i < 8) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (ldt == 3'd1 && v[31]) v[63:32] = 32'hFFFF_FFFF;
    return v;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] wdata, input int off);
    logic [63:0] v;
    v = 64'd0;
    for (int i = 0; i < 8; i++)
      if (i + off < 8) v[8*(i+off) +: 8] = wdata[8*i +: 8];
    return v;
  endfunction

  function automatic logic [7:0] model_wmask(input logic [7:0] wmask, input int off, input logic store);
    logic [7:0] v;
    v = 8'd0;
    for (int i = 0; i < 8; i++)
      if (store && wmask[i] && (i + off < 8)) v[i+off] = 1'b1;
    return v;
  endfunction

  function automatic logic model_misaligned(input int off, input logic store, input logic [7:0] wmask,
                                            input logic [2:0] ldt);
    int sz;
    sz = 1;
`ifdef LSU_MISALIGN_CHECK_EN
    if (store) sz = (wmask == 8'hFF) ? 8 : (wmask == 8'h03) ? 2 : 1;
    else       sz = (ldt == 3'd2) ? 8 : (ldt == 3'd1) ? 4 : 1;
`endif
    return (off % sz) != 0;
  endfunction

  // rsp_dly: -1 = response in the handshake cycle, k >= 0 = in WAIT cycle k.
  task automatic run_txn(input string tag, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wmask, input logic store, input logic [2:0] ldt,
                         input logic [63:0] rdata, input int ready_dly, input int rsp_dly);
    int off, exp_lat, waitc, req_cyc, wait_cyc;
    bit legal, mis, exp_err, hs, got;
    logic [63:0] exp_rdata;
    off   = int'(addr[2:0]);
    legal = store || (ldt == 3'd1) || (ldt == 3'd2) || (ldt == 3'd4);
    @(negedge clk);
    chk({tag, ".req_ready"}, 64'(bus.req_ready), 64'd1);
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_wmask = wmask;
    bus.req_store = store; bus.req_ld_type = ldt; bus.mem_rdata = rdata;
    bus.req_valid = 1'b1;
    if (!legal) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk({tag, ".ignored_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, ".ignored_mrv"}, 64'(bus.mem_req_valid), 64'd0);
      return;
    end
    mis = model_misaligned(off, store, wmask, ldt);
    if (mis) begin
      exp_lat = 1;
      exp_err = 1'b1;
    end else if (rsp_dly < 0) begin
      exp_lat = ready_dly + 2;
      exp_err = 1'b0;
    end else begin
      waitc   = (rsp_dly < TMO) ? rsp_dly + 1 : TMO;
      exp_lat = ready_dly + 2 + waitc;
      exp_err = (rsp_dly >= TMO);
    end
    exp_rdata = (exp_err || store) ? 64'd0 : model_load(rdata, off, ldt);
    hs = 0; got = 0; req_cyc = 0; wait_cyc = 0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.resp_valid) begin
        got = 1;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        chk({tag, ".latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, ".resp_err"}, 64'(bus.resp_err), 64'(exp_err));
        chk({tag, ".resp_rdata"}, bus.resp_rdata, exp_rdata);
        chk({tag, ".done_mrv"}, 64'(bus.mem_req_valid), 64'd0);
      end else if (!hs) begin
        chk({tag, ".mem_req_valid"}, 64'(bus.mem_req_valid), 64'd1);
        if (req_cyc == 0) begin
          chk({tag, ".mem_addr"}, bus.mem_addr, addr & ~64'h7);
          chk({tag, ".mem_wen"}, 64'(bus.mem_wen), 64'(store));
          chk({tag, ".mem_wdata"}, bus.mem_wdata, model_wdata(wdata, off));
          chk({tag, ".mem_wmask"}, 64'(bus.mem_wmask), 64'(model_wmask(wmask, off, store)));
          chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
        end
        bus.mem_req_ready = (req_cyc >= ready_dly);
        bus.mem_rsp_valid = bus.mem_req_ready && (rsp_dly < 0);
        hs = bus.mem_req_ready;
        req_cyc++;
      end else begin
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = (wait_cyc == rsp_dly);
        wait_cyc++;
      end
    end
    if (!got) begin
      tests++; fails++;
      $error("FAIL %s.timeout_wait: observed=no resp_valid expected=resp_valid", tag);
      return;
    end
    @(negedge clk);
    chk({tag, ".resp_pulse"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, ".ready_after"}, 64'(bus.req_ready), 64'd1);
    chk({tag, ".rdata_hold"}, bus.resp_rdata, exp_rdata);
    chk({tag, ".err_hold"}, 64'(bus.resp_err), 64'(exp_err));
  endtask

  initial begin
    logic [63:0] ra, wd, rd;
    logic [2:0]  ldt;
    logic [7:0]  wm;
    logic [7:0]  masks [4];
    logic [2:0]  ldts [3];
    masks = '{8'h01, 8'h03, 8'h0F, 8'hFF};
    ldts  = '{3'd1, 3'd2, 3'd4};
    bus.req_valid = 0; bus.req_addr = 0; bus.req_wdata = 0; bus.req_wmask = 0;
    bus.req_store = 0; bus.req_ld_type = 0; bus.mem_req_ready = 0;
    bus.mem_rsp_valid = 0; bus.mem_rdata = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst.resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst.resp_err", 64'(bus.resp_err), 64'd0);
    chk("rst.resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst.mem_addr", bus.mem_addr, 64'd0);
    chk("rst.mem_wdata", bus.mem_wdata, 64'd0);
    chk("rst.mem_wmask", 64'(bus.mem_wmask), 64'd0);
    chk("rst.mem_wen", 64'(bus.mem_wen), 64'd0);

    bus.mem_rsp_valid = 1'b1;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    chk("idle_stray.resp_valid", 64'(bus.resp_valid), 64'd0);

    run_txn("ld", 64'h8000_0010, 64'd0, 8'hFF, 1'b0, 3'd2, 64'h1122334455667788, 0, 0);
    run_txn("lw_sext", 64'h8000_0004, 64'd0, 8'h0F, 1'b0, 3'd1, 64'h8765432100000000, 0, 0);
    run_txn("lbu", 64'h8000_0003, 64'd0, 8'h01, 1'b0, 3'd4, 64'h00000000F0000000, 0, 0);
    run_txn("sh", 64'h8000_0006, 64'h0000_0000_0000_ABCD, 8'h03, 1'b1, 3'd0, 64'd0, 0, 0);
    run_txn("timeout", 64'h8000_0020, 64'd0, 8'hFF, 1'b0, 3'd2, 64'hDEAD_BEEF_0000_0001, 0, 99);
    run_txn("same_cycle_rsp", 64'h8000_0028, 64'd0, 8'hFF, 1'b0, 3'd2, 64'h0123456789ABCDEF, 1, -1);
    run_txn("last_wait_rsp", 64'h8000_0030, 64'd0, 8'h0F, 1'b0, 3'd1, 64'h0000_0000_7FFF_FFFF, 0, TMO - 1);
    run_txn("not_a_load", 64'h8000_0040, 64'd0, 8'hFF, 1'b0, 3'd3, 64'd0, 0, 0);
    run_txn("store_prio", 64'h8000_0048, 64'hCAFE_F00D_1234_5678, 8'hFF, 1'b1, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
    run_txn("sd_trunc", 64'h8000_0051, 64'h1111_2222_3333_4444, 8'hFF, 1'b1, 3'd0, 64'd0, 0, 0);
`ifdef LSU_MISALIGN_CHECK_EN
    run_txn("ld_misaligned", 64'h8000_0002, 64'd0, 8'hFF, 1'b0, 3'd2, 64'h5555_5555_5555_5555, 0, 0);
`endif

    // Reset in WAIT, then a late response must not produce a result.
    @(negedge clk);
    bus.req_addr = 64'h8000_0060; bus.req_store = 1'b0; bus.req_ld_type = 3'd2;
    bus.req_wmask = 8'hFF; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.mem_req_ready = 1'b1;
    @(negedge clk);
    bus.mem_req_ready = 1'b0;
    chk("rst_mid.in_wait_busy", 64'(bus.busy), 64'd1);
    chk("rst_mid.in_wait_mrv", 64'(bus.mem_req_valid), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid.busy", 64'(bus.busy), 64'd0);
    chk("rst_mid.req_ready", 64'(bus.req_ready), 64'd1);
    bus.mem_rsp_valid = 1'b1;
    @(negedge clk);
    bus.mem_rsp_valid = 1'b0;
    chk("rst_mid.no_resp1", 64'(bus.resp_valid), 64'd0);
    chk("rst_mid.busy_late", 64'(bus.busy), 64'd0);
    @(negedge clk);
    chk("rst_mid.no_resp2", 64'(bus.resp_valid), 64'd0);

    for (int n = 0; n < 40; n++) begin
      ra  = {32'h0000_0000, 32'h8000_0000 | ($urandom & 32'h0000_0FFF)};
      wd  = {$urandom, $urandom};
      rd  = {$urandom, $urandom};
      wm  = masks[$urandom_range(0, 3)];
      ldt = ldts[$urandom_range(0, 2)];
      run_txn($sformatf("rnd%0d", n), ra, wd, wm, 1'($urandom_range(0, 1)), ldt, rd,
              int'($urandom_range(0, 2)), int'($urandom_range(0, 6)) - 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed=still running expected=finished");
    $fatal(1, "bench time limit");
  end
endmodule
